// File: rtl/alu_pipe.sv
// alu_pipe: single-stage ALU with carry/zero flags, branch resolution and backpressure.
// Define ALU_PIPE_MUL_EN to add the iterative shift-add multiplier on opcode 1110.
module alu_pipe #(
  parameter int WIDTH  = 16,
  parameter int PC_INC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [1:0]       cond,
  input  logic             comp,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic [WIDTH-1:0] pc,
  input  logic [WIDTH-1:0] imm,
  input  logic             wb_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_wb,
  output logic             carry,
  output logic             zero,
  output logic             branch,
  output logic [WIDTH-1:0] branch_addr,
  output logic             busy
);
  localparam logic [3:0] OP_ADD = 4'h0, OP_ADDI = 4'h1, OP_NAND = 4'h2, OP_LLI = 4'h3;
  localparam logic [3:0] OP_LW = 4'h4, OP_SW = 4'h5, OP_BEQ = 4'h8, OP_BLT = 4'h9;
  localparam logic [3:0] OP_BLE = 4'hA, OP_JAL = 4'hC, OP_JRI = 4'hD, OP_MUL = 4'hE;
  logic             r_valid, r_wb, r_carry, r_zero, r_branch, r_busy;
  logic [WIDTH-1:0] r_result, r_baddr;
  logic             w_acc, w_is_mul, w_alu, w_exec, w_cin, w_taken, w_br, w_wb, w_upd;
  logic             w_mul_done, w_mul_wb;
  logic [3:0]       w_op;
  logic [WIDTH-1:0] w_op2, w_res, w_addr, w_mul_res;
  logic [WIDTH:0]   w_sum;
  assign in_ready = ~rst & ~r_busy & (~r_valid | out_ready);
  assign w_acc    = in_valid & in_ready;
  assign w_op     = (opcode inside {OP_ADD, OP_ADDI, OP_NAND, OP_LLI, OP_LW, OP_SW,
                                    OP_BEQ, OP_BLT, OP_BLE, OP_JAL, OP_JRI}) ? opcode : OP_ADD;
  assign w_alu    = (w_op == OP_ADD) || (w_op == OP_NAND);
  assign w_op2    = (w_alu & comp) ? ~op2 : op2;
  assign w_exec   = ~w_alu | ((cond == 2'b01) ? zero : (cond == 2'b10) ? carry : 1'b1);
  assign w_cin    = (w_op == OP_ADD) && (cond == 2'b11) && carry;
  assign w_sum    = {1'b0, op1} + {1'b0, ((w_op == OP_ADDI) ? imm : w_op2)} + {{WIDTH{1'b0}}, w_cin};
  assign w_taken  = (w_op == OP_BEQ) ? (op1 == op2) :
                    (w_op == OP_BLT) ? (op1 < op2)  :
                    (w_op == OP_BLE) ? (op1 <= op2) : 1'b0;
  assign w_br     = w_taken | (w_op == OP_JAL) | (w_op == OP_JRI);
  assign w_addr   = (w_op == OP_JRI) ? op1 + imm : (w_taken | (w_op == OP_JAL)) ? pc + imm : '0;
  assign w_wb     = wb_en & w_exec & ~(w_op inside {OP_BEQ, OP_BLT, OP_BLE, OP_JRI});
  assign w_upd    = w_acc & ~w_is_mul & wb_en & w_exec & (w_alu | (w_op == OP_ADDI));
  assign w_res    = ~w_exec                                  ? '0 :
                    (w_op == OP_ADD || w_op == OP_ADDI)      ? w_sum[WIDTH-1:0] :
                    (w_op == OP_NAND)                        ? ~(op1 & w_op2) :
                    (w_op == OP_LLI)                         ? imm :
                    (w_op == OP_LW || w_op == OP_SW)         ? op1 + imm :
                    (w_op == OP_JAL)                         ? pc + WIDTH'(PC_INC) : '0;
`ifdef ALU_PIPE_MUL_EN
  localparam int CW = $clog2(WIDTH + 1);
  logic [WIDTH-1:0] r_mcand, r_mplier, r_macc;
  logic [CW-1:0]    r_cnt;
  logic             r_mwb;
  assign w_is_mul   = opcode == OP_MUL;
  assign w_mul_res  = r_macc + (r_mplier[0] ? r_mcand : '0);
  assign w_mul_done = r_busy && (r_cnt == CW'(1));
  assign w_mul_wb   = r_mwb;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_macc   <= '0;
      r_mwb    <= 1'b0;
    end else if (w_acc & w_is_mul) begin
      r_busy   <= 1'b1;
      r_cnt    <= CW'(WIDTH);
      r_mcand  <= op1;
      r_mplier <= op2;
      r_macc   <= '0;
      r_mwb    <= wb_en;
    end else if (r_busy) begin
      r_macc   <= w_mul_res;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt - CW'(1);
      r_busy   <= ~w_mul_done;
    end
  end
`else
  assign w_is_mul   = 1'b0;
  assign w_mul_res  = '0;
  assign w_mul_done = 1'b0;
  assign w_mul_wb   = 1'b0;
  assign r_busy     = 1'b0;
`endif
  // a MUL accept empties the output stage; its result arrives later via w_mul_done
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid  <= 1'b0;
      r_result <= '0;
      r_wb     <= 1'b0;
      r_branch <= 1'b0;
      r_baddr  <= '0;
      r_carry  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      if (w_acc & ~w_is_mul) begin
        r_valid  <= 1'b1;
        r_result <= w_res;
        r_wb     <= w_wb;
        r_branch <= w_br;
        r_baddr  <= w_addr;
      end else if (w_mul_done) begin
        r_valid  <= 1'b1;
        r_result <= w_mul_res;
        r_wb     <= w_mul_wb;
        r_branch <= 1'b0;
        r_baddr  <= '0;
      end else if (out_ready | w_acc) begin
        r_valid  <= 1'b0;
      end
      if (w_upd) begin
        r_zero <= w_res == '0;
        if (w_op != OP_NAND) r_carry <= w_sum[WIDTH];
      end
    end
  end
  assign out_valid   = r_valid;
  assign result      = r_result;
  assign out_wb      = r_wb;
  assign carry       = r_carry;
  assign zero        = r_zero;
  assign branch      = r_branch;
  assign branch_addr = r_baddr;
  assign busy        = r_busy;
endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: random and directed checks of alu_pipe against an arithmetic reference model.
module tb_alu_pipe;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b0;
  logic        in_ready, comp = 1'b0, wb_en = 1'b0;
  logic [3:0]  opcode = '0;
  logic [1:0]  cond = '0;
  logic [15:0] op1 = '0, op2 = '0, pc = '0, imm = '0;
  logic        out_valid, out_wb, carry, zero, branch, busy;
  logic [15:0] result, branch_addr;
  int          n_chk = 0, n_err = 0;
  bit          m_carry = 0, m_zero = 0, e_wb, e_br;
  logic [15:0] e_res, e_ba;

  alu_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode),
    .cond(cond), .comp(comp), .op1(op1), .op2(op2), .pc(pc), .imm(imm), .wb_en(wb_en),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_wb(out_wb),
    .carry(carry), .zero(zero), .branch(branch), .branch_addr(branch_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outcome from the instruction rules, using plain integer arithmetic.
  task automatic ref_model(input logic [3:0] o_in, input logic [1:0] cd, input logic cp,
                           input logic [15:0] a_in, b_in, p_in, im_in, input logic we);
    int o, a, b, p, im, b2, s;
    bit alu, ex;
    o = o_in; a = a_in; b = b_in; p = p_in; im = im_in; s = 0;
    if (!(o inside {0, 1, 2, 3, 4, 5, 8, 9, 10, 12, 13})) o = 0;
    alu = (o == 0 || o == 2);
    b2  = (alu && cp) ? 65535 - b : b;
    ex  = !alu || cd == 0 || cd == 3 || (cd == 1 && m_zero) || (cd == 2 && m_carry);
    e_res = 0; e_wb = 0; e_br = 0; e_ba = 0;
    if (!ex) return;
    case (o)
      0:       begin s = a + b2 + ((cd == 3 && m_carry) ? 1 : 0); e_res = 16'(s % 65536); e_wb = we; end
      1:       begin s = a + im; e_res = 16'(s % 65536); e_wb = we; end
      2:       begin e_res = 16'(65535 - (a & b2)); e_wb = we; end
      3:       begin e_res = 16'(im); e_wb = we; end
      4, 5:    begin e_res = 16'((a + im) % 65536); e_wb = we; end
      8, 9, 10: begin
        e_br = (o == 8) ? (a == b) : (o == 9) ? (a < b) : (a <= b);
        e_ba = e_br ? 16'((p + im) % 65536) : 16'h0;
      end
      12:      begin e_br = 1; e_ba = 16'((p + im) % 65536); e_res = 16'((p + 1) % 65536); e_wb = we; end
      13:      begin e_br = 1; e_ba = 16'((a + im) % 65536); end
      default: ;
    endcase
    if (we && o <= 2) begin
      m_zero = (e_res == 0);
      if (o != 2) m_carry = (s > 65535);
    end
  endtask

  task automatic drive(input logic [3:0] o, input logic [1:0] cd, input logic cp,
                       input logic [15:0] a, b, p, im, input logic we);
    opcode = o; cond = cd; comp = cp; op1 = a; op2 = b; pc = p; imm = im; wb_en = we;
  endtask

  task automatic issue(input logic [3:0] o, input logic [1:0] cd, input logic cp,
                       input logic [15:0] a, b, p, im, input logic we);
    drive(o, cd, cp, a, b, p, im, we);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("in_ready", in_ready, 1);
    ref_model(o, cd, cp, a, b, p, im, we);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("out_valid", out_valid, 1);
    check("result", result, e_res);
    check("out_wb", out_wb, e_wb);
    check("branch", branch, e_br);
    check("branch_addr", branch_addr, e_ba);
    check("carry", carry, m_carry);
    check("zero", zero, m_zero);
  endtask

  task automatic reset_check();
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_wb", out_wb, 0);
    check("rst_flags", {carry, zero}, 0);
    check("rst_branch", {branch, branch_addr}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0; m_carry = 0; m_zero = 0;
    #1;
    check("rel_in_ready", in_ready, 1);
  endtask

  initial begin
    logic [15:0] hold_res, a, b;
    logic [3:0]  o;
    repeat (2) @(posedge clk);
    #1;
    reset_check();
    // add overflow to zero with carry
    issue(4'h0, 2'b00, 0, 16'hFFFF, 16'h0001, 0, 0, 1);
    check("r031_res", result, 16'h0000);
    check("r031_cz", {carry, zero}, 2'b11);
    // conditional add fails when zero is clear
    issue(4'h0, 2'b00, 0, 16'h0001, 16'h0001, 0, 0, 1);
    issue(4'h0, 2'b01, 0, 16'h0003, 16'h0004, 0, 0, 1);
    check("r032_wb", out_wb, 0);
    check("r032_res", result, 0);
    check("r032_cz", {carry, zero}, 2'b00);
    issue(4'h9, 2'b00, 0, 16'h0003, 16'h0005, 16'h0010, 16'h0004, 0);
    check("r033_blt", {branch, branch_addr}, {1'b1, 16'h0014});
    issue(4'h8, 2'b00, 0, 16'h0005, 16'h0003, 16'h0010, 16'h0004, 0);
    check("r033_beq", {branch, branch_addr}, {1'b0, 16'h0000});
    // backpressure: second op waits until the first is taken
    @(posedge clk); #1;
    drive(4'h1, 2'b00, 0, 16'h0005, 0, 0, 16'h0006, 1);
    in_valid = 1'b1; out_ready = 1'b0;
    #1;
    check("bp_ir0", in_ready, 1);
    ref_model(4'h1, 2'b00, 0, 16'h0005, 0, 0, 16'h0006, 1);
    hold_res = e_res;
    @(posedge clk); #1;
    drive(4'h3, 2'b00, 0, 0, 0, 0, 16'h1234, 1);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_ir", in_ready, 0);
      check("bp_valid", out_valid, 1);
      check("bp_res", result, hold_res);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    check("bp_ir1", in_ready, 1);
    ref_model(4'h3, 2'b00, 0, 0, 0, 0, 16'h1234, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_valid2", out_valid, 1);
    check("bp_res2", result, 16'h1234);
    @(posedge clk); #1;
    check("bp_drop", out_valid, 0);
    // random instruction stream
    for (int n = 0; n < 300; n++) begin
      o = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
      if (o == 4'hE) o = 4'h0;
`endif
      a = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 3)) : 16'($urandom);
      if ($urandom_range(0, 5) == 0) b = a;
      issue(o, 2'($urandom_range(0, 3)), 1'($urandom), a, b, 16'($urandom), 16'($urandom), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
        check("idle_drop", out_valid, 0);
      end
    end
`ifdef ALU_PIPE_MUL_EN
    // multiply stalls the next op, then an aborted multiply produces nothing
    drive(4'hE, 2'b00, 0, 16'h0012, 16'h0034, 0, 0, 1);
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check("mul_ir0", in_ready, 1);
    @(posedge clk); #1;
    drive(4'h0, 2'b00, 0, 16'h0001, 16'h0002, 0, 0, 1);
    #1;
    for (int i = 1; i <= 16; i++) begin
      check("mul_busy", busy, 1);
      check("mul_ir", in_ready, 0);
      check("mul_ov", out_valid, 0);
      @(posedge clk); #1;
    end
    check("mul_valid", out_valid, 1);
    check("mul_res", result, 16'h03A8);
    check("mul_wb", out_wb, 1);
    check("mul_busy_end", busy, 0);
    check("mul_flags", {carry, zero}, {m_carry, m_zero});
    check("mul_ir_end", in_ready, 1);
    ref_model(4'h0, 2'b00, 0, 16'h0001, 16'h0002, 0, 0, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("post_mul_res", result, e_res);
    drive(4'hE, 2'b00, 0, 16'h0007, 16'h0009, 0, 0, 1);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; m_carry = 0; m_zero = 0;
    for (int i = 0; i < 20; i++) begin
      check("abort_ov", out_valid, 0);
      check("abort_busy", busy, 0);
      @(posedge clk); #1;
    end
`endif
    reset_check();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
